inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, instruction width in bits; multiple of 8.
- DEPTH, 256, number of instruction words.
- ADDR_W, 32, fetch address width.
- BYTE_ADDR, 1, 1 = byte address (word index = addr >> log2(DATA_W/8)); 0 = word address.
- NOP_WORD, 32'h00000000, instruction returned on a faulting fetch.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-low reset.
- load_en, in, 1, high = loader session open.
- load_valid, in, 1, load_byte is valid this cycle.
- load_byte, in, 8, image byte, most significant byte of each word first.
- req_valid, in, 1, fetch request.
- req_addr, in, ADDR_W, fetch address.
- req_ready, out, 1, fetch accepted when req_valid && req_ready.
- rsp_valid, out, 1, response valid.
- rsp_instr, out, DATA_W, fetched instruction.
- rsp_fault, out, 1, fetch was misaligned or out of the loaded range.
- word_count, out, log2(DEPTH)+1, number of words in the loaded image.
- load_ovf, out, 1, sticky: bytes arrived after the memory was full.
- load_partial, out, 1, sticky: the session closed with an incomplete word.
- running, out, 1, high in state RUN.

Function
REQ-003 The FSM SHALL have three states: IDLE, LOAD, RUN.
REQ-004 Transitions SHALL be:
- IDLE -> LOAD when load_en = 1.
- LOAD -> RUN when load_en = 0.
- RUN -> LOAD when load_en = 1.
- IDLE is entered only on reset.
REQ-005 On entering LOAD: write pointer, byte counter and word_count SHALL clear to 0; load_ovf and load_partial SHALL clear.
REQ-006 In LOAD, each load_valid byte SHALL shift into a word assembler.
- After DATA_W/8 bytes, the word is written at the write pointer in the same cycle.
- The pointer and word_count then increment.
REQ-007 Bytes arriving when word_count = DEPTH SHALL be discarded and SHALL set load_ovf.
REQ-008 If LOAD exits with the byte counter non-zero, the partial word SHALL be discarded and load_partial SHALL be set.
REQ-009 req_ready SHALL be 1 only in RUN; fetch requests in IDLE or LOAD are not accepted.
REQ-010 A fetch accepted in cycle N SHALL produce rsp_valid = 1 in cycle N+1 with registered rsp_instr and rsp_fault; latency is exactly 1.
- With back-to-back requests, one response is produced per cycle.
REQ-011 rsp_fault SHALL be 1, and rsp_instr = NOP_WORD, when either condition holds:
- BYTE_ADDR = 1 and the low log2(DATA_W/8) address bits are non-zero.
- The word index is >= word_count.
REQ-012 A fetch accepted in the same cycle that load_en rises SHALL still respond in the next cycle.
- req_ready drops from the following cycle.
REQ-013 Address bits above the word index SHALL participate in the range check; there is no wrap-around.

Reset
REQ-014 When rst = 0 at a rising edge, the block SHALL set:
- state IDLE;
- req_ready, rsp_valid, rsp_fault, running = 0;
- rsp_instr = NOP_WORD;
- word_count = 0, load_ovf = 0, load_partial = 0;
- write pointer and byte counter = 0.
REQ-015 Memory array contents SHALL NOT be cleared by reset.
- Reset during LOAD abandons the session.
- A subsequent fetch SHALL fault, because word_count = 0.

Structure
REQ-016 A shared package SHALL hold the state enum (IDLE, LOAD, RUN) and the default NOP_WORD constant.
REQ-017 The storage array SHALL be a sub-module, imem_array: synchronous write, registered read, DEPTH x DATA_W.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Load bytes 12 34 56 78 9A BC DE F0, drop load_en, fetch 0x0 then 0x4 -> word_count = 2, responses 0x12345678 then 0x9ABCDEF0, each one cycle after acceptance, rsp_fault = 0.
- After a 2-word load, fetch 0x8 and 0x2 -> rsp_fault = 1, rsp_instr = 0x00000000 for both.
- Load 257 words with DEPTH = 256 -> word_count = 256, load_ovf = 1, fetch 0x3FC returns word 255.
- Load 5 bytes, drop load_en -> word_count = 1, load_partial = 1.
- Assert rst = 0 in the middle of a load -> all outputs match REQ-014 next cycle, and fetch 0x0 after a RUN entry faults.
- Issue back-to-back fetches 0x0, 0x4, 0x0 -> three consecutive rsp_valid cycles with the correct data.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state codes and
// the default instruction returned on a faulting fetch.
package inst_mem_loader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Bit width able to index n items, never less than one.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Fetch request/response bus of the instruction memory loader.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_fault;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/inst_mem_loader_array.sv
// DEPTH x DATA_W instruction storage: synchronous write, registered read,
// contents are never reset.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream image loader plus single-cycle-latency instruction fetch port.
// Bytes arrive MSB-first; fetches are served only once the session is closed.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  inst_mem_loader_if.slave         fetch,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     load_ovf,
  output logic                     load_partial,
  output logic                     running
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = bits_for(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BC_W  = bits_for(BYTES);
  localparam int SH    = $clog2(BYTES);

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  wr_ptr;
  logic [BC_W-1:0]   bcnt;
  logic [DATA_W-1:0] asm_q;

  logic enter_load, exit_load, byte_in, full, last_byte, wr_en;
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_en)  state_nxt = ST_LOAD;
      ST_LOAD: if (!load_en) state_nxt = ST_RUN;
      ST_RUN:  if (load_en)  state_nxt = ST_LOAD;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  assign enter_load = load_en && (state != ST_LOAD);
  assign exit_load  = (state == ST_LOAD) && !load_en;
  assign byte_in    = (state == ST_LOAD) && load_en && load_valid;
  assign full       = (word_count == CNT_W'(DEPTH));
  assign last_byte  = (bcnt == BC_W'(BYTES - 1));
  assign wr_en      = byte_in && !full && last_byte;
  assign wr_word    = {asm_q[DATA_W-9:0], load_byte};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      bcnt         <= '0;
      word_count   <= '0;
      load_ovf     <= 1'b0;
      load_partial <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_load) begin
        wr_ptr       <= '0;
        bcnt         <= '0;
        word_count   <= '0;
        load_ovf     <= 1'b0;
        load_partial <= 1'b0;
      end else begin
        if (byte_in) begin
          if (full) begin
            load_ovf <= 1'b1;
          end else if (last_byte) begin
            bcnt       <= '0;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        // An unfinished word is dropped when the session closes.
        if (exit_load) begin
          bcnt <= '0;
          if (bcnt != '0) load_partial <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_in && !full) asm_q <= wr_word;
  end

  logic              accept, misalign, out_of_range, fault;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1, fault_p1, nop_p1;

  assign fetch.req_ready = (state == ST_RUN);
  assign running         = (state == ST_RUN);
  assign accept          = fetch.req_valid && fetch.req_ready;

  // Full-width compare: upper address bits must be zero, no aliasing.
  assign idx          = (BYTE_ADDR != 0) ? (fetch.req_addr >> SH) : fetch.req_addr;
  assign misalign     = (BYTE_ADDR != 0) && ((fetch.req_addr & ADDR_W'(BYTES - 1)) != '0);
  assign out_of_range = (idx >= ADDR_W'(word_count));
  assign fault        = misalign || out_of_range;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .re    (accept),
    .raddr (idx[IDX_W-1:0]),
    .rdata (rd_data_p1)
  );

  // Stage p1: response registered one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      nop_p1   <= 1'b1;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        fault_p1 <= fault;
        nop_p1   <= fault;
      end
    end
  end

  assign fetch.rsp_valid = vld_p1;
  assign fetch.rsp_fault = fault_p1;
  assign fetch.rsp_instr = nop_p1 ? NOP_WORD : rd_data_p1;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader against a byte-level reference model.
module tb_inst_mem_loader;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_byte = 8'h00;
  logic [8:0] word_count;
  logic       load_ovf, load_partial, running;

  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus();

  inst_mem_loader #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .ADDR_W    (32),
    .BYTE_ADDR (1),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .fetch        (bus),
    .word_count   (word_count),
    .load_ovf     (load_ovf),
    .load_partial (load_partial),
    .running      (running)
  );

  // Reference model: image words, count, sticky flags, pending bytes.
  logic [31:0] m_mem [DEPTH];
  int          m_wc;
  bit          m_ovf, m_partial;
  logic [7:0]  m_buf [$];
  logic [31:0] aq [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick();
    m_wc = 0; m_ovf = 0; m_partial = 0;
    m_buf.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
    if (m_wc == DEPTH) m_ovf = 1;
    else begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        m_mem[m_wc] = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
        m_wc++;
        m_buf.delete();
      end
    end
  endtask

  task automatic end_load();
    load_en = 1'b0;
    tick();
    m_partial = (m_buf.size() != 0);
    m_buf.delete();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_wc"},      32'(word_count),   32'(m_wc));
    chk({tag, "_ovf"},     32'(load_ovf),     32'(m_ovf));
    chk({tag, "_partial"}, 32'(load_partial), 32'(m_partial));
    chk({tag, "_running"}, 32'(running),      32'd1);
  endtask

  task automatic model_rsp(input logic [31:0] a, output logic [31:0] ei, output logic ef);
    logic [31:0] w;
    w = a >> 2;
    if (a[1:0] != 2'b00 || w >= 32'(m_wc)) begin ef = 1'b1; ei = 32'h0; end
    else begin ef = 1'b0; ei = m_mem[w]; end
  endtask

  // Back-to-back fetches of every address in aq, then one idle cycle.
  task automatic fetch_burst(input string tag);
    logic [31:0] ei;
    logic        ef;
    foreach (aq[i]) begin
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      model_rsp(aq[i], ei, ef);
      bus.req_valid = 1'b1;
      bus.req_addr  = aq[i];
      tick();
      chk({tag, "_vld"},   32'(bus.rsp_valid), 32'd1);
      chk({tag, "_instr"}, bus.rsp_instr,      ei);
      chk({tag, "_fault"}, 32'(bus.rsp_fault), 32'(ef));
    end
    bus.req_valid = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},   32'(bus.req_ready), 32'd0);
    chk({tag, "_vld"},     32'(bus.rsp_valid), 32'd0);
    chk({tag, "_fault"},   32'(bus.rsp_fault), 32'd0);
    chk({tag, "_instr"},   bus.rsp_instr,      32'h0);
    chk({tag, "_running"}, 32'(running),       32'd0);
    chk({tag, "_wc"},      32'(word_count),    32'd0);
    chk({tag, "_ovf"},     32'(load_ovf),      32'd0);
    chk({tag, "_partial"}, 32'(load_partial),  32'd0);
  endtask

  initial begin
    logic [31:0] ei;
    logic        ef;
    int          nb;
    logic [7:0]  img [8];

    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    m_wc = 0; m_ovf = 0; m_partial = 0;

    rst = 1'b0;
    tick(); tick();
    chk_reset_state("por");
    rst = 1'b1;
    tick();

    // Two-word image, aligned fetches then faulting fetches.
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    start_load();
    foreach (img[i]) send_byte(img[i]);
    end_load();
    chk("two_wc_abs", 32'(word_count), 32'd2);
    chk_status("two");
    aq.delete(); aq.push_back(32'h0); aq.push_back(32'h4);
    fetch_burst("two_fetch");
    chk("two_w0_abs", m_mem[0], 32'h1234_5678);
    aq.delete(); aq.push_back(32'h8); aq.push_back(32'h2);
    fetch_burst("two_fault");
    aq.delete(); aq.push_back(32'h0); aq.push_back(32'h4); aq.push_back(32'h0);
    fetch_burst("b2b");
    aq.delete(); aq.push_back(32'h1000_0000); aq.push_back(32'hFFFF_FC00);
    fetch_burst("nowrap");

    // Fetch accepted in the cycle load_en rises, then ignored while loading.
    model_rsp(32'h4, ei, ef);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    load_en       = 1'b1;
    tick();
    chk("rise_vld",   32'(bus.rsp_valid), 32'd1);
    chk("rise_instr", bus.rsp_instr,      ei);
    chk("rise_fault", 32'(bus.rsp_fault), 32'(ef));
    chk("rise_ready", 32'(bus.req_ready), 32'd0);
    chk("rise_wc",    32'(word_count),    32'd0);
    m_wc = 0; m_ovf = 0; m_partial = 0; m_buf.delete();
    tick();
    chk("load_noacc", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    end_load();
    chk_status("reload");
    aq.delete(); aq.push_back(32'h4); aq.push_back(32'h0); aq.push_back(32'h8);
    fetch_burst("reload_fetch");

    // Partial word.
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    end_load();
    chk("part_flag_abs", 32'(load_partial), 32'd1);
    chk_status("part");
    aq.delete(); aq.push_back(32'h0); aq.push_back(32'h4);
    fetch_burst("part_fetch");

    // Overflow: 257 words into a 256-word memory.
    start_load();
    for (int i = 0; i < 257 * 4; i++) send_byte(8'($urandom));
    end_load();
    chk("ovf_wc_abs", 32'(word_count), 32'd256);
    chk("ovf_flag_abs", 32'(load_ovf), 32'd1);
    chk_status("ovf");
    aq.delete(); aq.push_back(32'h3FC); aq.push_back(32'h400); aq.push_back(32'h0);
    aq.push_back(32'h3FD);
    fetch_burst("ovf_fetch");

    // Random sessions with random fetch mixes.
    for (int s = 0; s < 5; s++) begin
      nb = int'($urandom_range(0, 40));
      start_load();
      for (int i = 0; i < nb; i++) send_byte(8'($urandom));
      end_load();
      chk_status("rnd");
      aq.delete();
      for (int k = 0; k < 6; k++) aq.push_back(32'($urandom_range(0, 4 * (m_wc + 2))));
      aq.push_back(32'h0100_0000 | 32'(4 * $urandom_range(0, 3)));
      fetch_burst("rnd_fetch");
    end

    // Reset in the middle of a session.
    start_load();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    rst = 1'b0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_reset_state("midrst");
    rst = 1'b1;
    load_en = 1'b0;
    tick();
    chk("midrst_idle", 32'(running), 32'd0);
    start_load();
    end_load();
    chk_status("midrst_run");
    aq.delete(); aq.push_back(32'h0);
    fetch_burst("midrst_fetch");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
